// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stall, branch flush, multi-cycle divide stall.
// Define DIV_STALL_EN to enable divide stall sequencing; without it the divide is single-cycle.
module pipeline_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        BranchTaken,
    input  logic        Div_Start,
    input  logic        StallClear,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        IDEXHold,
    output logic        DivBusy,
    output logic [15:0] StallCount
);

    if (DIV_CYCLES < 2 || DIV_CYCLES > 64) begin : g_cfg_check
        $error("DIV_CYCLES must lie in 2..64");
    end

    logic        w_load_use;
    logic        w_div_stall;
    logic [15:0] r_stall_cnt;

    assign w_load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                        ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

`ifdef DIV_STALL_EN
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } state_t;

    // The RUN cycle that sees Div_Start is the first stall cycle, hence the -2.
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_div_cnt;
    logic [5:0] w_div_cnt_nxt;

    assign w_div_stall = (r_state == DIV_BUSY) ||
                         ((r_state == RUN) && Div_Start && !BranchTaken);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= RUN;
            r_div_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        case (r_state)
            RUN: begin
                if (w_div_stall) begin
                    w_state_nxt   = DIV_BUSY;
                    w_div_cnt_nxt = DIV_LOAD;
                end
            end
            DIV_BUSY: begin
                if (r_div_cnt == '0) begin
                    w_state_nxt = DIV_DONE;
                end else begin
                    w_div_cnt_nxt = r_div_cnt - 6'd1;
                end
            end
            DIV_DONE: w_state_nxt = RUN;
            default:  w_state_nxt = RUN;
        endcase
    end
`else
    logic w_unused_div;

    assign w_div_stall  = 1'b0;
    assign w_unused_div = Div_Start;
`endif

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        IDEXHold   = 1'b0;
        DivBusy    = 1'b0;
        if (w_div_stall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXHold  = 1'b1;
            DivBusy   = 1'b1;
        end else if (BranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (w_load_use) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stall_cnt <= '0;
        end else if (StallClear) begin
            r_stall_cnt <= '0;
        end else if (!PCWrite && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed + random stimulus against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TB_DIV = 32;
`ifdef DIV_STALL_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mr = 1'b0;
    logic [4:0]  ex_rt = '0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        br = 1'b0;
    logic        ds = 1'b0;
    logic        clr = 1'b0;
    logic        pcw, ifidw, flush, bubble, hold, busy;
    logic [15:0] scnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DIV_CYCLES(TB_DIV)) dut (
        .Clk(clk), .Reset_n(rst_n), .IDEX_MemRead(mr), .IDEX_Rt(ex_rt),
        .IFID_Rs(id_rs), .IFID_Rt(id_rt), .BranchTaken(br), .Div_Start(ds),
        .StallClear(clr), .PCWrite(pcw), .IFIDWrite(ifidw), .IFIDFlush(flush),
        .IDEXBubble(bubble), .IDEXHold(hold), .DivBusy(busy), .StallCount(scnt)
    );

    typedef struct packed {
        logic [5:0]  ctrl;   // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXHold, DivBusy}
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: stall cycles still owed by the divide, and whether this cycle follows a finished divide.
    int   div_left = 0;
    bit   after_div = 1'b0;
    int   m_cnt = 0;

    task automatic cycle(input bit r, input bit m, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input bit b, input bit d, input bit c);
        exp_t e;
        int   nl;
        bit   na, dst, lu;
        @(posedge clk);
        #1;
        rst_n = r; mr = m; ex_rt = xrt; id_rs = rs; id_rt = rt; br = b; ds = d; clr = c;
        if (!r) begin
            div_left = 0; after_div = 1'b0; m_cnt = 0;
        end
        nl = div_left; na = after_div; dst = 1'b0;
        lu = m && (xrt != 0) && (xrt == rs || xrt == rt);
        if (div_left > 0) begin
            dst = 1'b1; nl = div_left - 1; na = (nl == 0);
        end else if (DIV_EN && !after_div && d && !b) begin
            dst = 1'b1; nl = TB_DIV - 1; na = 1'b0;
        end else begin
            na = 1'b0;
        end
        if (dst)      e.ctrl = 6'b000011;
        else if (b)   e.ctrl = 6'b111100;
        else if (lu)  e.ctrl = 6'b000100;
        else          e.ctrl = 6'b110000;
        e.cnt = 16'(m_cnt);
        q.push_back(e);
        if (r) begin
            div_left = nl; after_div = na;
            if (c)                              m_cnt = 0;
            else if (!e.ctrl[5] && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({pcw, ifidw, flush, bubble, hold, busy} !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl t=%0t got=%b exp=%b", $time,
                             {pcw, ifidw, flush, bubble, hold, busy}, e.ctrl);
                end
                checks++;
                if (scnt !== e.cnt) begin
                    errors++;
                    $display("FAIL stallcount t=%0t got=%h exp=%h", $time, scnt, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        cycle(0, 1, 5, 5, 0, 0, 1, 0);       // reset active: RUN rules still apply
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        cycle(1, 1, 5, 5, 9, 0, 0, 0);       // load-use on Rs
        cycle(1, 1, 7, 3, 7, 0, 0, 0);       // load-use on Rt
        cycle(1, 1, 0, 0, 0, 0, 0, 0);       // $zero never hazards
        cycle(1, 0, 5, 5, 5, 0, 0, 0);       // not a load
        cycle(1, 1, 5, 5, 0, 1, 0, 0);       // branch beats load-use
        cycle(1, 0, 0, 0, 0, 1, 1, 0);       // branch suppresses divide start
        idle(1);
        cycle(1, 0, 0, 0, 0, 0, 0, 1);       // clear count before divide
        for (int i = 0; i < TB_DIV + 8; i++) cycle(1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < TB_DIV + 4; i++) cycle(1, 1, 2, 2, 2, i % 3 == 0, 0, 0);
        // async reset part-way through a divide
        for (int i = 0; i < 11; i++) cycle(1, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (busy !== 1'b0 || scnt !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset busy=%b cnt=%h exp busy=0 cnt=0000", busy, scnt);
        end
        idle(2);
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 63) == 0);
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        idle(TB_DIV + 2);
        // drive the counter into saturation with back-to-back load-use stalls
        for (int i = 0; i < 65540; i++) cycle(1, 1, 4, 4, 1, 0, 0, 0);
        cycle(1, 1, 4, 4, 1, 0, 0, 1);       // clear wins over increment
        cycle(1, 1, 4, 4, 1, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one parameter: DIV_CYCLES, default 32, total stall cycles per divide (legal range 2..64).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Clk  input  1  rising-edge clock shared with the pipeline registers.
REQ-004 Reset_n  input  1  asynchronous active-low reset.
REQ-005 IDEX_MemRead  input  1  the instruction in EX is a load.
REQ-006 IDEX_Rt  input  5  destination register of the EX load.
REQ-007 IFID_Rs, IFID_Rt  input  5 each  source registers of the instruction in ID.
REQ-008 BranchTaken  input  1  branch resolved taken in EX.
REQ-009 Div_Start  input  1  a divide instruction occupies EX.
REQ-010 StallClear  input  1  synchronous clear of StallCount.
REQ-011 PCWrite  output  1  PC update enable.
REQ-012 IFIDWrite  output  1  IF/ID register load enable.
REQ-013 IFIDFlush  output  1  zero IF/ID contents on the next edge.
REQ-014 IDEXBubble  output  1  load zeroed control fields into ID/EX on the next edge.
REQ-015 IDEXHold  output  1  ID/EX keeps its current contents on the next edge.
REQ-016 DivBusy  output  1  a divide stall is in progress.
REQ-017 StallCount  output  16  saturating count of cycles with PCWrite=0.

Function
REQ-018 State machine states SHALL be RUN, DIV_BUSY and DIV_DONE; a 6-bit down-counter DivCnt SHALL time DIV_BUSY.
REQ-019 LoadUse SHALL be combinational: IDEX_MemRead=1, IDEX_Rt!=0, and IDEX_Rt equal to IFID_Rs or IFID_Rt.
REQ-020 DivStall SHALL be asserted in DIV_BUSY, and in RUN when Div_Start=1 and BranchTaken=0; it SHALL never be asserted in DIV_DONE.
REQ-021 Priority SHALL be DivStall > BranchTaken > LoadUse; with none active: PCWrite=1, IFIDWrite=1, all other control outputs 0.
REQ-022 DivStall SHALL drive PCWrite=0, IFIDWrite=0, IDEXHold=1, DivBusy=1, IFIDFlush=0, IDEXBubble=0.
REQ-023 BranchTaken without DivStall SHALL drive PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXBubble=1.
REQ-024 LoadUse alone SHALL drive PCWrite=0, IFIDWrite=0, IDEXBubble=1 for exactly that cycle.
REQ-025 RUN to DIV_BUSY SHALL occur on an edge with DivStall=1, loading DivCnt=DIV_CYCLES-2.
REQ-026 In DIV_BUSY, DivCnt SHALL decrement each edge; at DivCnt=0 the next state SHALL be DIV_DONE.
REQ-027 A divide SHALL therefore stall exactly DIV_CYCLES consecutive cycles: one RUN cycle plus DIV_CYCLES-1 DIV_BUSY cycles.
REQ-028 DIV_DONE SHALL last one cycle, ignore Div_Start, evaluate BranchTaken and LoadUse normally, then return to RUN.
REQ-029 In DIV_BUSY, BranchTaken and LoadUse SHALL be ignored.
REQ-030 StallCount SHALL increment on each edge where PCWrite=0 and saturate at 0xFFFF.
REQ-031 StallClear=1 SHALL set StallCount to 0 on the next edge, overriding any increment.

Reset
REQ-032 Reset_n=0 SHALL immediately force state RUN, DivCnt=0 and StallCount=0, including mid-divide.
REQ-033 During reset, the outputs SHALL follow the RUN combinational rules for the current inputs.

Configuration
REQ-034 With DIV_STALL_EN defined, divide sequencing SHALL behave as specified above.
REQ-035 Without DIV_STALL_EN, the state machine and DivCnt SHALL be omitted, and DivStall and DivBusy SHALL be constant 0 (single-cycle divide).

Verification
REQ-036 IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 for one cycle -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 that cycle; StallCount increases by 1.
REQ-037 IDEX_Rt=0 with IFID_Rs=0 and IDEX_MemRead=1 -> no stall; PCWrite=1.
REQ-038 Div_Start held high (DIV_CYCLES=32) -> PCWrite=0 for exactly 32 cycles, DIV_DONE cycle PCWrite=1, no re-trigger; StallCount=32.
REQ-039 BranchTaken=1 together with LoadUse -> IFIDFlush=1, IDEXBubble=1, PCWrite=1; BranchTaken=1 in RUN with Div_Start=1 -> flush, no divide stall.
REQ-040 Reset_n pulsed low at DIV_BUSY cycle 10 -> state RUN, DivBusy=0 asynchronously; StallCount at 0xFFFF plus stall -> stays 0xFFFF; StallClear during stall -> 0.
